add_sub_pipe: RTL and testbench

- Parametrised, pipelined integer adder/subtractor. Successor of the single-cycle 8-bit registered adder.
- The carry chain is split into STAGES equal slices, one slice per pipeline stage, so long words close timing.
- Valid/ready handshake on both sides; one result per cycle when not stalled.
- Produces result plus carry/borrow, signed-overflow and zero flags; sits between the register file read port and the writeback mux.

---
 rtl/add_sub_pipe.sv | 183 ++++++++++++++++++
 tb/tb_add_sub_pipe.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/add_sub_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : add_sub_pipe                                                 |
// | Description : Pipelined integer adder/subtractor. The carry chain is cut   |
// |               into STAGES equal slices and one slice is added per stage.   |
// |               Valid/ready on both sides, one result per cycle when the     |
// |               consumer keeps up. Produces result, carry/borrow, signed     |
// |               overflow and zero flags.                                     |
// | Options     : `define ADD_PIPE_SAT_EN adds input 'sat'. When sat=1 and the |
// |               result overflows, Out clamps to the signed max/min.          |
// | Ports       : clock, reset_n (async, active-low)                           |
// |               in_valid/in_ready, In1 (A), In2 (B), op, carry_in [, sat]    |
// |               out_valid/out_ready, Out, carry_out, overflow, zero          |
// |               op: 00 ADD, 01 SUB, 10 ADC, 11 SBB                           |
// | Revision    : 1.0 - initial pipelined release                             |
// +----------------------------------------------------------------------------+
module add_sub_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] In1,
  input  logic [WIDTH-1:0] In2,
  input  logic [1:0]       op,
  input  logic             carry_in,
`ifdef ADD_PIPE_SAT_EN
  input  logic             sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Out,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int c_SLICE = WIDTH / STAGES;

  // Whole pipeline moves together: it advances whenever the output register
  // is empty or is being drained this cycle.
  logic             w_adv;
  logic [WIDTH-1:0] w_bp;
  logic             w_c0;

  // Per-stage registers. r_acc holds finished sum slices in its low bits and
  // the not-yet-added A slices in its high bits; r_bp carries B' forward.
  logic             r_v   [STAGES];
  logic [WIDTH-1:0] r_acc [STAGES];
  logic [WIDTH-1:0] r_bp  [STAGES];
  logic             r_c   [STAGES];
  logic             r_sub [STAGES];
`ifdef ADD_PIPE_SAT_EN
  logic             r_sat [STAGES];
`endif
  logic             r_ovf;
  logic             r_zero;

  // Inputs seen by each stage: the ports for stage 0, the previous stage's
  // registers otherwise.
  logic             w_src_v   [STAGES];
  logic [WIDTH-1:0] w_src_acc [STAGES];
  logic [WIDTH-1:0] w_src_bp  [STAGES];
  logic             w_src_c   [STAGES];
  logic             w_src_sub [STAGES];
`ifdef ADD_PIPE_SAT_EN
  logic             w_src_sat [STAGES];
`endif

  assign w_adv    = !r_v[STAGES-1] || out_ready;
  assign in_ready = w_adv;

  // op[0] selects subtraction (invert B), op[1] selects use of carry_in.
  assign w_bp = op[0] ? ~In2 : In2;
  assign w_c0 = op[1] ? (carry_in ^ op[0]) : op[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int c_LO = k * c_SLICE;

    logic [c_SLICE:0] w_add;
    logic [WIDTH-1:0] w_nxt_acc;

    if (k == 0) begin : g_head
      assign w_src_v[k]   = in_valid;
      assign w_src_acc[k] = In1;
      assign w_src_bp[k]  = w_bp;
      assign w_src_c[k]   = w_c0;
      assign w_src_sub[k] = op[0];
`ifdef ADD_PIPE_SAT_EN
      assign w_src_sat[k] = sat;
`endif
    end else begin : g_body
      assign w_src_v[k]   = r_v[k-1];
      assign w_src_acc[k] = r_acc[k-1];
      assign w_src_bp[k]  = r_bp[k-1];
      assign w_src_c[k]   = r_c[k-1];
      assign w_src_sub[k] = r_sub[k-1];
`ifdef ADD_PIPE_SAT_EN
      assign w_src_sat[k] = r_sat[k-1];
`endif
    end

    assign w_add = {1'b0, w_src_acc[k][c_LO +: c_SLICE]}
                 + {1'b0, w_src_bp[k][c_LO +: c_SLICE]}
                 + {{c_SLICE{1'b0}}, w_src_c[k]};

    always_comb begin
      w_nxt_acc                   = w_src_acc[k];
      w_nxt_acc[c_LO +: c_SLICE]  = w_add[c_SLICE-1:0];
    end

    if (k == STAGES - 1) begin : g_tail
      logic             w_a_msb;
      logic             w_b_msb;
      logic             w_ovf;
      logic [WIDTH-1:0] w_res;

      // The MSB slice is added here, so A and B' MSBs are still intact in
      // the forwarded operand bits.
      assign w_a_msb = w_src_acc[k][WIDTH-1];
      assign w_b_msb = w_src_bp[k][WIDTH-1];
      assign w_ovf   = (w_a_msb == w_b_msb) && (w_add[c_SLICE-1] != w_a_msb);

      always_comb begin
        w_res = w_nxt_acc;
`ifdef ADD_PIPE_SAT_EN
        if (w_src_sat[k] && w_ovf) begin
          w_res = w_a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
      end

      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          r_v[k]   <= 1'b0;
          r_acc[k] <= '0;
          r_c[k]   <= 1'b0;
          r_ovf    <= 1'b0;
          r_zero   <= 1'b0;
        end else if (w_adv) begin
          r_v[k]   <= w_src_v[k];
          r_acc[k] <= w_res;
          // For subtraction the raw carry is "no borrow", so invert it.
          r_c[k]   <= w_add[c_SLICE] ^ w_src_sub[k];
          r_ovf    <= w_ovf;
          r_zero   <= (w_res == '0);
        end
      end
    end else begin : g_mid
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          r_v[k]   <= 1'b0;
          r_acc[k] <= '0;
          r_bp[k]  <= '0;
          r_c[k]   <= 1'b0;
          r_sub[k] <= 1'b0;
`ifdef ADD_PIPE_SAT_EN
          r_sat[k] <= 1'b0;
`endif
        end else if (w_adv) begin
          r_v[k]   <= w_src_v[k];
          r_acc[k] <= w_nxt_acc;
          r_bp[k]  <= w_src_bp[k];
          r_c[k]   <= w_add[c_SLICE];
          r_sub[k] <= w_src_sub[k];
`ifdef ADD_PIPE_SAT_EN
          r_sat[k] <= w_src_sat[k];
`endif
        end
      end
    end
  end

  assign out_valid = r_v[STAGES-1];
  assign Out       = r_acc[STAGES-1];
  assign carry_out = r_c[STAGES-1];
  assign overflow  = r_ovf;
  assign zero      = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_add_sub_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_add_sub_pipe                                              |
// | Description : Scoreboard bench for add_sub_pipe (WIDTH=8, STAGES=2).       |
// |               Directed vectors push hand-computed results into a queue;   |
// |               a monitor pops and compares on every output transfer.        |
// | Revision    : 1.0 - initial                                               |
// +----------------------------------------------------------------------------+
module tb_add_sub_pipe;

  localparam int         WIDTH  = 8;
  localparam int         STAGES = 2;
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_ADC = 2'b10;
  localparam logic [1:0] OP_SBB = 2'b11;

  logic             clock     = 1'b0;
  logic             reset_n   = 1'b0;
  logic             in_valid  = 1'b0;
  logic             out_ready = 1'b1;
  logic             carry_in  = 1'b0;
  logic [WIDTH-1:0] In1       = '0;
  logic [WIDTH-1:0] In2       = '0;
  logic [1:0]       op        = 2'b00;
`ifdef ADD_PIPE_SAT_EN
  logic             sat       = 1'b0;
`endif
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] Out;
  logic             carry_out;
  logic             overflow;
  logic             zero;

  typedef struct {
    logic [7:0] o;
    logic       c;
    logic       v;
    logic       z;
    logic       lat;
    int         t;
  } exp_t;

  exp_t  q[$];
  exp_t  e_m;
  int    n_chk     = 0;
  int    n_fail    = 0;
  int    cyc       = 0;
  logic  saw_stall = 1'b0;
  logic  p_valid   = 1'b0;
  logic  p_ready   = 1'b1;
  logic [10:0] p_out = '0;

  add_sub_pipe #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .In1       (In1),
    .In2       (In2),
    .op        (op),
    .carry_in  (carry_in),
`ifdef ADD_PIPE_SAT_EN
    .sat       (sat),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Out       (Out),
    .carry_out (carry_out),
    .overflow  (overflow),
    .zero      (zero)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Present one beat, wait (bounded) for the handshake, record the expected result.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [1:0] o,
                      input logic ci, input logic [7:0] eo, input logic ec,
                      input logic ev, input logic ez, input logic lat);
    int   n;
    bit   got;
    exp_t x;
    In1 = a; In2 = b; op = o; carry_in = ci; in_valid = 1'b1;
    n = 0; got = 0;
    while (!got && n < 50) begin
      @(negedge clock);
      if (in_ready) got = 1;
      else n++;
    end
    if (got) begin
      x.o = eo; x.c = ec; x.v = ev; x.z = ez; x.lat = lat; x.t = cyc;
      q.push_back(x);
    end else begin
      n_chk++; n_fail++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, expected 1", n);
    end
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clock);
      n++;
    end
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: %0d results still pending, expected 0", nm, q.size());
      q.delete();
    end
    @(posedge clock); #1;
  endtask

  // Monitor: sample at the falling edge; a transfer happens at the next rising edge.
  always @(negedge clock) begin
    if (reset_n) begin
      chk("in_ready_rule", {31'd0, in_ready}, {31'd0, (!out_valid || out_ready)});
      if (p_valid && !p_ready && out_valid)
        chk("hold_stable", {21'd0, Out, carry_out, overflow, zero}, {21'd0, p_out});
      if (out_valid && !out_ready && !in_ready) saw_stall = 1'b1;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_out: got Out=0x%0h with no beat pending, expected none", Out);
        end else begin
          e_m = q.pop_front();
          chk("Out",       {24'd0, Out},       {24'd0, e_m.o});
          chk("carry_out", {31'd0, carry_out}, {31'd0, e_m.c});
          chk("overflow",  {31'd0, overflow},  {31'd0, e_m.v});
          chk("zero",      {31'd0, zero},      {31'd0, e_m.z});
          if (e_m.lat) chk("latency", cyc - e_m.t, STAGES);
        end
      end
      p_valid = out_valid;
      p_ready = out_ready;
      p_out   = {Out, carry_out, overflow, zero};
    end else begin
      p_valid = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_Out",       {24'd0, Out},       32'd0);
    chk("rst_carry",     {31'd0, carry_out}, 32'd0);
    chk("rst_overflow",  {31'd0, overflow},  32'd0);
    chk("rst_zero",      {31'd0, zero},      32'd0);
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    #2 reset_n = 1'b1;
    @(posedge clock); #1;

    // Directed arithmetic: a, b, op, cin -> Out, carry, ovf, zero
    send(8'h01, 8'hFE, OP_ADD, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1);
    send(8'h05, 8'h07, OP_SUB, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b0, 1'b1);
    send(8'h7F, 8'h01, OP_ADD, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1);
    send(8'hFF, 8'h00, OP_ADC, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1);
    send(8'h10, 8'h0F, OP_SBB, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    drain("directed");

    // Back-to-back stream with a 3-cycle consumer stall in the middle
    fork
      begin
        send(8'h10, 8'h20, OP_ADD, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0);
        send(8'h80, 8'h01, OP_SUB, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0, 1'b0);
        send(8'h0F, 8'h01, OP_ADC, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0);
        send(8'h00, 8'h00, OP_SBB, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
        send(8'h80, 8'h80, OP_ADD, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0);
        send(8'h33, 8'h33, OP_SUB, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        send(8'h0F, 8'hF0, OP_ADC, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
        send(8'h05, 8'h03, OP_SBB, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      begin
        repeat (3) @(posedge clock);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1 out_ready = 1'b1;
      end
    join
    drain("stream");
    chk("stall_seen", {31'd0, saw_stall}, 32'd1);

    // Reset with two beats in flight
    out_ready = 1'b0;
    send(8'h01, 8'h01, OP_ADD, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0);
    send(8'h03, 8'h04, OP_ADD, 1'b0, 8'h07, 1'b0, 1'b0, 1'b0, 1'b0);
    #3 reset_n = 1'b0;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_Out",       {24'd0, Out},       32'd0);
    chk("midrst_flags",     {29'd0, carry_out, overflow, zero}, 32'd0);
    q.delete();
    @(negedge clock);
    @(posedge clock);
    #2 reset_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      chk("post_rst_idle", {31'd0, out_valid}, 32'd0);
    end
    @(posedge clock); #1;
    send(8'h55, 8'hAA, OP_ADD, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1);
    drain("post_reset");

`ifdef ADD_PIPE_SAT_EN
    // Saturation: clamp only when sat=1 and overflow; flags unchanged
    sat = 1'b1;
    send(8'h7F, 8'h01, OP_ADD, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0, 1'b1);
    sat = 1'b0;
    send(8'h7F, 8'h01, OP_ADD, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1);
    sat = 1'b1;
    send(8'h80, 8'h01, OP_SUB, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1);
    sat = 1'b0;
    drain("saturate");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
